// File: rtl/program_loader.sv
// rtl/program_loader.sv - serial in-system programming front end for the program memory write port.
// Optional read-back verify path enabled by defining PROGRAM_LOADER_VERIFY_EN.
`timescale 1ns/1ps
module program_loader #(
    parameter int ADDR_WIDTH    = 13,
    parameter int INSTR_WIDTH   = 14,
    parameter int PAYLOAD_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   pgm_en,
    input  logic                   pgm_sclk,
    input  logic                   pgm_sdi,
    output logic                   cpu_hold,
    output logic                   busy,
    output logic                   mem_wr_en,
    output logic [ADDR_WIDTH-1:0]  mem_wr_addr,
    output logic [INSTR_WIDTH-1:0] mem_wr_data
`ifdef PROGRAM_LOADER_VERIFY_EN
    ,
    output logic                   mem_rd_en,
    output logic [ADDR_WIDTH-1:0]  mem_rd_addr,
    input  logic [INSTR_WIDTH-1:0] mem_rd_data,
    output logic                   pgm_sdo
`endif
);
    localparam int DW = (ADDR_WIDTH > INSTR_WIDTH) ? ADDR_WIDTH : INSTR_WIDTH;
    localparam int CW = $clog2(PAYLOAD_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_PAYLOAD, S_WRITE, S_RD_REQ, S_RD_SHIFT
    } state_t;

    state_t                 r_state;
    logic                   r_en_s1, r_en_s2, r_en_d;
    logic                   r_sclk_s1, r_sclk_s2, r_sclk_d;
    logic                   r_sdi_s1, r_sdi_s2;
    logic [ADDR_WIDTH-1:0]  r_ptr;
    logic [DW-1:0]          r_shift;
    logic [CW-1:0]          r_cnt;
    logic                   r_op_write;
    logic                   r_cpu_hold, r_busy, r_wr_en;
    logic [ADDR_WIDTH-1:0]  r_wr_addr;
    logic [INSTR_WIDTH-1:0] r_wr_data;
`ifdef PROGRAM_LOADER_VERIFY_EN
    logic                     r_rd_en;
    logic [ADDR_WIDTH-1:0]    r_rd_addr;
    logic [PAYLOAD_WIDTH-1:0] r_rd_shift;
    logic                     w_sclk_fall;
    assign w_sclk_fall = r_sclk_d & ~r_sclk_s2;
`endif

    logic          w_sclk_rise, w_en_rise;
    logic [DW-1:0] w_frame;
    assign w_sclk_rise = r_sclk_s2 & ~r_sclk_d;
    assign w_en_rise   = r_en_s2 & ~r_en_d;
    // Only the low DW bits of a frame are kept; earlier bits fall off the top.
    assign w_frame     = {r_shift[DW-2:0], r_sdi_s2};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_en_s1    <= 1'b0; r_en_s2   <= 1'b0; r_en_d   <= 1'b0;
            r_sclk_s1  <= 1'b0; r_sclk_s2 <= 1'b0; r_sclk_d <= 1'b0;
            r_sdi_s1   <= 1'b0; r_sdi_s2  <= 1'b0;
            r_ptr      <= '0;
            r_shift    <= '0;
            r_cnt      <= '0;
            r_op_write <= 1'b0;
            r_cpu_hold <= 1'b0;
            r_busy     <= 1'b0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
`ifdef PROGRAM_LOADER_VERIFY_EN
            r_rd_en    <= 1'b0;
            r_rd_addr  <= '0;
            r_rd_shift <= '0;
`endif
        end else begin
            r_en_s1   <= pgm_en;   r_en_s2   <= r_en_s1;   r_en_d   <= r_en_s2;
            r_sclk_s1 <= pgm_sclk; r_sclk_s2 <= r_sclk_s1; r_sclk_d <= r_sclk_s2;
            r_sdi_s1  <= pgm_sdi;  r_sdi_s2  <= r_sdi_s1;

            if (r_state != S_IDLE && !r_en_s2) begin
                r_state    <= S_IDLE;
                r_cnt      <= '0;
                r_cpu_hold <= 1'b0;
                r_busy     <= 1'b0;
                r_wr_en    <= 1'b0;
`ifdef PROGRAM_LOADER_VERIFY_EN
                r_rd_en    <= 1'b0;
                r_rd_shift <= '0;
`endif
            end else begin
                case (r_state)
                    S_IDLE: if (w_en_rise) begin
                        r_state    <= S_CMD;
                        r_ptr      <= '0;
                        r_cnt      <= '0;
                        r_cpu_hold <= 1'b1;
                    end
                    S_CMD: if (w_sclk_rise) begin
                        r_shift <= w_frame;
                        if (r_cnt == CW'(3)) begin
                            r_cnt <= '0;
                            case (w_frame[3:0])
                                4'h1: begin r_op_write <= 1'b0; r_state <= S_PAYLOAD; end
                                4'h2: begin r_op_write <= 1'b1; r_state <= S_PAYLOAD; end
                                4'h3: r_ptr <= r_ptr + ADDR_WIDTH'(1);
`ifdef PROGRAM_LOADER_VERIFY_EN
                                4'h4: begin
                                    r_state   <= S_RD_REQ;
                                    r_rd_en   <= 1'b1;
                                    r_rd_addr <= r_ptr;
                                    r_busy    <= 1'b1;
                                end
`endif
                                default: ;
                            endcase
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                    S_PAYLOAD: if (w_sclk_rise) begin
                        r_shift <= w_frame;
                        if (r_cnt == CW'(PAYLOAD_WIDTH - 1)) begin
                            r_cnt <= '0;
                            if (r_op_write) begin
                                r_state   <= S_WRITE;
                                r_wr_en   <= 1'b1;
                                r_wr_addr <= r_ptr;
                                r_wr_data <= w_frame[INSTR_WIDTH-1:0];
                                r_busy    <= 1'b1;
                            end else begin
                                r_ptr   <= w_frame[ADDR_WIDTH-1:0];
                                r_state <= S_CMD;
                            end
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                    S_WRITE: begin
                        r_wr_en <= 1'b0;
                        r_busy  <= 1'b0;
                        r_ptr   <= r_ptr + ADDR_WIDTH'(1);
                        r_state <= S_CMD;
                    end
`ifdef PROGRAM_LOADER_VERIFY_EN
                    // Two cycles here: one for the request, one for the memory to return data.
                    S_RD_REQ: begin
                        r_rd_en <= 1'b0;
                        if (r_cnt == '0) begin
                            r_cnt <= CW'(1);
                        end else begin
                            r_cnt      <= '0;
                            r_rd_shift <= PAYLOAD_WIDTH'(mem_rd_data);
                            r_state    <= S_RD_SHIFT;
                        end
                    end
                    S_RD_SHIFT: if (w_sclk_fall) begin
                        r_rd_shift <= {r_rd_shift[PAYLOAD_WIDTH-2:0], 1'b0};
                        if (r_cnt == CW'(PAYLOAD_WIDTH - 1)) begin
                            r_cnt      <= '0;
                            r_ptr      <= r_ptr + ADDR_WIDTH'(1);
                            r_busy     <= 1'b0;
                            r_rd_shift <= '0;
                            r_state    <= S_CMD;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
`endif
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign cpu_hold    = r_cpu_hold;
    assign busy        = r_busy;
    assign mem_wr_en   = r_wr_en;
    assign mem_wr_addr = r_wr_addr;
    assign mem_wr_data = r_wr_data;
`ifdef PROGRAM_LOADER_VERIFY_EN
    assign mem_rd_en   = r_rd_en;
    assign mem_rd_addr = r_rd_addr;
    assign pgm_sdo     = r_rd_shift[PAYLOAD_WIDTH-1];
`endif
endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - scoreboard bench for program_loader (PROGRAM_LOADER_VERIFY_EN optional).
`timescale 1ns/1ps
module tb_program_loader;
    localparam int AW = 13;
    localparam int IW = 14;
    localparam int PW = 16;

    logic          clk = 1'b0, rst_n = 1'b0, pgm_en = 1'b0, pgm_sclk = 1'b0, pgm_sdi = 1'b0;
    logic          cpu_hold, busy, mem_wr_en;
    logic [AW-1:0] mem_wr_addr;
    logic [IW-1:0] mem_wr_data;
`ifdef PROGRAM_LOADER_VERIFY_EN
    logic          mem_rd_en, pgm_sdo;
    logic [AW-1:0] mem_rd_addr;
    logic [IW-1:0] mem_rd_data = '0;
    always @(posedge clk) if (mem_rd_en) mem_rd_data <= (mem_rd_addr == 13'd2) ? 14'h30CD : 14'h0;
`endif

    program_loader #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .PAYLOAD_WIDTH(PW)) dut (
        .clk(clk), .rst_n(rst_n), .pgm_en(pgm_en), .pgm_sclk(pgm_sclk), .pgm_sdi(pgm_sdi),
        .cpu_hold(cpu_hold), .busy(busy), .mem_wr_en(mem_wr_en),
        .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data)
`ifdef PROGRAM_LOADER_VERIFY_EN
        , .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data), .pgm_sdo(pgm_sdo)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [AW-1:0] a; logic [IW-1:0] d; } wr_t;
    wr_t  exp_q[$];
    wr_t  mon_e;
    logic prev_wr = 1'b0;
    int   n_pass = 0, n_total = 0;

    always @(negedge clk) begin
        if (mem_wr_en) begin
            n_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_write got addr=%h data=%h, expected no write", mem_wr_addr, mem_wr_data);
            end else begin
                mon_e = exp_q.pop_front();
                if ({mem_wr_addr, mem_wr_data} !== mon_e)
                    $display("FAIL write_value got addr=%h data=%h, expected addr=%h data=%h",
                             mem_wr_addr, mem_wr_data, mon_e.a, mon_e.d);
                else n_pass++;
            end
            n_total++;
            if (prev_wr) $display("FAIL strobe_width got mem_wr_en high 2 cycles, expected 1");
            else n_pass++;
        end
        prev_wr = mem_wr_en;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout, expected completion");
        $fatal(1);
    end

    task automatic clk_wait(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, output logic sdo_s);
        pgm_sdi = b;
        clk_wait(2);
        pgm_sclk = 1'b1;
        clk_wait(8);
`ifdef PROGRAM_LOADER_VERIFY_EN
        sdo_s = pgm_sdo;
`else
        sdo_s = 1'b0;
`endif
        pgm_sclk = 1'b0;
        clk_wait(8);
    endtask

    task automatic send_bits(input logic [15:0] v, input int n);
        logic s;
        for (int i = n - 1; i >= 0; i--) send_bit(v[i], s);
    endtask

    task automatic send_frame(input logic [3:0] c, input logic [15:0] p);
        send_bits({12'h0, c}, 4);
        send_bits(p, 16);
    endtask

    task automatic check_drained(input string name);
        clk_wait(3);
        n_total++;
        if (exp_q.size() != 0) $display("FAIL %s got %0d pending writes, expected 0", name, exp_q.size());
        else n_pass++;
    endtask

    task automatic restart_session();
        pgm_en = 1'b0;
        clk_wait(6);
        pgm_en = 1'b1;
        clk_wait(6);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clk_wait(3);
        n_total++;
        if ({cpu_hold, busy, mem_wr_en, mem_wr_addr, mem_wr_data} !== '0)
            $display("FAIL reset_outputs got hold=%b busy=%b we=%b addr=%h data=%h, expected all 0",
                     cpu_hold, busy, mem_wr_en, mem_wr_addr, mem_wr_data);
        else n_pass++;
        rst_n = 1'b1;
        clk_wait(2);
    endtask

    task automatic test_write_basic();
        pgm_en = 1'b1;
        clk_wait(6);
        n_total++;
        if ({cpu_hold, busy} !== 2'b10) $display("FAIL hold_in_cmd got hold=%b busy=%b, expected 1 0", cpu_hold, busy);
        else n_pass++;
        exp_q.push_back({13'h0000, 14'h30AB});
        send_frame(4'h2, 16'h30AB);
        check_drained("write_basic");
        n_total++;
        if ({mem_wr_addr, mem_wr_data} !== {13'h0000, 14'h30AB})
            $display("FAIL hold_values got addr=%h data=%h, expected 0000 30ab", mem_wr_addr, mem_wr_data);
        else n_pass++;
    endtask

    task automatic test_wrap();
        send_frame(4'h1, 16'h1FFF);
        exp_q.push_back({13'h1FFF, 14'h0001});
        exp_q.push_back({13'h0000, 14'h0001});
        send_frame(4'h2, 16'h0001);
        send_frame(4'h2, 16'h0001);
        check_drained("wrap");
    endtask

    task automatic test_abort();
        send_bits(16'h0002, 4);
        send_bits(16'hABCD >> 7, 9);
        pgm_en = 1'b0;
        clk_wait(6);
        n_total++;
        if ({cpu_hold, busy} !== 2'b00) $display("FAIL abort_idle got hold=%b busy=%b, expected 0 0", cpu_hold, busy);
        else n_pass++;
        check_drained("abort_no_write");
        pgm_en = 1'b1;
        clk_wait(6);
        exp_q.push_back({13'h0000, 14'h3234});
        send_frame(4'h2, 16'hF234);
        check_drained("abort_reenable");
    endtask

    task automatic test_unknown_inc();
        restart_session();
        send_bits(16'h000F, 4);
`ifndef PROGRAM_LOADER_VERIFY_EN
        send_bits(16'h0004, 4);
`endif
        send_bits(16'h0003, 4);
        exp_q.push_back({13'h0001, 14'h2801});
        send_frame(4'h2, 16'h2801);
        check_drained("unknown_inc");
    endtask

    task automatic test_reset_mid();
        logic ok;
        ok = 1'b0;
        send_bits(16'h0002, 4);
        send_bits(16'h1555 >> 1, 15);
        pgm_sdi = 1'b1;
        clk_wait(2);
        pgm_sclk = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(posedge clk); #1;
            ok = mem_wr_en;
        end
        n_total++;
        if ({busy, mem_wr_en} !== 2'b11) $display("FAIL busy_write got busy=%b we=%b, expected 1 1", busy, mem_wr_en);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({cpu_hold, busy, mem_wr_en, mem_wr_addr, mem_wr_data} !== '0)
            $display("FAIL async_reset got hold=%b busy=%b we=%b addr=%h data=%h, expected all 0",
                     cpu_hold, busy, mem_wr_en, mem_wr_addr, mem_wr_data);
        else n_pass++;
        pgm_sclk = 1'b0;
        clk_wait(3);
        rst_n = 1'b1;
        clk_wait(6);
        exp_q.push_back({13'h0000, 14'h0555});
        send_frame(4'h2, 16'h0555);
        check_drained("after_reset");
    endtask

`ifdef PROGRAM_LOADER_VERIFY_EN
    task automatic test_verify();
        logic [15:0] got;
        logic        s;
        send_frame(4'h1, 16'h0002);
        send_bit(1'b0, s); send_bit(1'b1, s); send_bit(1'b0, s);
        send_bit(1'b0, s);
        got[15] = s;
        for (int i = 14; i >= 0; i--) begin
            send_bit(1'b0, s);
            got[i] = s;
        end
        n_total++;
        if (got !== 16'h30CD) $display("FAIL read_stream got %h, expected 30cd", got);
        else n_pass++;
        n_total++;
        if (pgm_sdo !== 1'b0) $display("FAIL sdo_idle got %b, expected 0", pgm_sdo);
        else n_pass++;
        exp_q.push_back({13'h0003, 14'h0042});
        send_frame(4'h2, 16'h0042);
        check_drained("read_ptr_inc");
    endtask
`endif

    initial begin
        test_reset();
        test_write_basic();
        test_wrap();
        test_abort();
        test_unknown_inc();
        test_reset_mid();
`ifdef PROGRAM_LOADER_VERIFY_EN
        test_verify();
`endif
        clk_wait(4);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
